// File: rtl/sra_seq_shifter_if.sv
// Handshake and data bundle for the iterative arithmetic right shifter.
// The requester drives start/a/b, and the shifter returns its status and result.
interface sra_seq_shifter_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             inexact;
    logic             err;

    modport master (
        output start, a, b,
        input  ready, done, result, inexact, err
    );

    modport slave (
        input  start, a, b,
        output ready, done, result, inexact, err
    );
endinterface

// File: rtl/sra_seq_shifter.sv
// Iterative arithmetic right shifter: one bit per clock with sign fill.
// A sticky bit records any 1 shifted out, and that sticky bit drives the inexact flag.
module sra_seq_shifter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    sra_seq_shifter_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_W = WIDTH'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] work_reg;
    logic [WIDTH-1:0] work_shift;
    logic             sticky_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] result_reg;
    logic             inexact_reg;
    logic             err_reg;

    logic             accept;
    logic             b_neg;
    logic [CW-1:0]    n_load;

    assign accept = (state_reg == IDLE) && bus.start;
    assign b_neg  = bus.b[WIDTH-1];
    // Counts of WIDTH or more all yield pure sign fill, so they clamp to WIDTH.
    assign n_load = (bus.b >= WIDTH_W) ? WIDTH_C : bus.b[CW-1:0];

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign work_shift[gi] = work_reg[gi+1];
        end
    endgenerate
    assign work_shift[WIDTH-1] = work_reg[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (b_neg || (n_load == '0)) state_next = DONE;
                    else                         state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (count_reg == CW'(1)) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state_reg == IDLE);
        bus.done  = (state_reg == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_reg    <= '0;
            sticky_reg  <= 1'b0;
            count_reg   <= '0;
            result_reg  <= '0;
            inexact_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else if (accept) begin
            work_reg   <= bus.a;
            sticky_reg <= 1'b0;
            count_reg  <= n_load;
            if (b_neg) begin
                result_reg  <= bus.a;
                inexact_reg <= 1'b0;
                err_reg     <= 1'b1;
            end else if (n_load == '0) begin
                result_reg  <= bus.a;
                inexact_reg <= 1'b0;
                err_reg     <= 1'b0;
            end
        end else if (state_reg == SHIFT) begin
            work_reg   <= work_shift;
            sticky_reg <= sticky_reg | work_reg[0];
            count_reg  <= count_reg - CW'(1);
            // Outputs take the post-shift values so they are stable for the whole DONE cycle.
            if (count_reg == CW'(1)) begin
                result_reg  <= work_shift;
                inexact_reg <= sticky_reg | work_reg[0];
                err_reg     <= 1'b0;
            end
        end
    end

    assign bus.result  = result_reg;
    assign bus.inexact = inexact_reg;
    assign bus.err     = err_reg;
endmodule
